srt2_csa_div: RTL and testbench

- Iterative radix-2 SRT fractional divider, parametrised in WIDTH.
- Keeps the partial remainder in carry-save form, built from a generic parametrised carry-save row.
- Produces the quotient with on-the-fly conversion and applies a final sign correction through one carry-propagate add.
- Sits in the arithmetic datapath wherever a multi-cycle divide is acceptable.

---
 rtl/srt_pkg.sv | 23 ++
 rtl/srt2_csa_div_if.sv | 34 +++
 rtl/csa_n.sv | 16 +
 rtl/srt2_csa_div.sv | 190 +++++++++++++++++++
 tb/tb_srt2_csa_div.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/srt_pkg.sv
// Shared types for the radix-2 SRT carry-save divider.
// Contents: FSM state enum, quotient-digit encoding, remainder-estimate width.
// Optional feature macro used by the divider files: SRT_STICKY_EN.
package srt_pkg;

    // Top bits of 2*sum + 2*carry examined for digit selection: sign, 2 integer, 1 fraction.
    localparam int unsigned EST_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Quotient digit in {-1, 0, +1}.
    typedef enum logic [1:0] {
        QD_ZERO = 2'b00,
        QD_POS  = 2'b01,
        QD_NEG  = 2'b11
    } qd_t;

endpackage

// File: rtl/srt2_csa_div_if.sv
// Request/response bundle of the SRT divider.
// master: drives start, x, d; receives busy, done, q, err (and sticky).
// slave : the divider side.
// sticky exists only when SRT_STICKY_EN is defined.
interface srt2_csa_div_if #(
    parameter int unsigned WIDTH = 11
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] d;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic             err;
`ifdef SRT_STICKY_EN
    logic             sticky;
`endif

    modport master (
        output start, x, d,
        input  busy, done, q, err
`ifdef SRT_STICKY_EN
        , input sticky
`endif
    );

    modport slave (
        input  start, x, d,
        output busy, done, q, err
`ifdef SRT_STICKY_EN
        , output sticky
`endif
    );
endinterface

// File: rtl/csa_n.sv
// Generic N-bit carry-save row (3:2 compressor per bit).
// Ports: a, b, c operands; cin injected at Carry[0]; Sum and Carry outputs.
// Carry is already shifted up by one; the carry out of bit N-1 is dropped.
module csa_n #(
    parameter int unsigned N = 14
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    input  logic         cin,
    output logic [N-1:0] Sum,
    output logic [N-1:0] Carry
);
    assign Sum   = a ^ b ^ c;
    assign Carry = {(a[N-2:0] & b[N-2:0]) | (a[N-2:0] & c[N-2:0]) | (b[N-2:0] & c[N-2:0]), cin};
endmodule

// File: rtl/srt2_csa_div.sv
// Iterative radix-2 SRT fractional divider, q = floor(x*2^WIDTH/d).
// Partial remainder kept in carry-save form, quotient built by on-the-fly
// conversion, final sign correction through one carry-propagate add.
// Ports: clk, reset (synchronous, active-high), io (slave modport:
//        start/x/d in, busy/done/q/err out, sticky out with SRT_STICKY_EN).
// Macro SRT_STICKY_EN: adds sticky = (final remainder != 0).
module srt2_csa_div
    import srt_pkg::*;
#(
    parameter int unsigned WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    srt2_csa_div_if.slave        io
);
    localparam int unsigned RW = WIDTH + 3;
    localparam int unsigned CW = $clog2(WIDTH);

    state_t            state_q, state_d;
    logic [RW-1:0]     sum_q, sum_d, carry_q, carry_d;
    logic [WIDTH-1:0]  d_q, d_d, qa_q, qa_d, qm_q, qm_d, q_q, q_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
`ifdef SRT_STICKY_EN
    logic              sticky_q, sticky_d;
`endif

    logic [EST_W-1:0]  y;
    qd_t               qd;
    logic [RW-1:0]     d_ext, csa_c, csa_sum, csa_carry;
    logic              w_neg;

    // Remainder estimate from the truncated top bits of 2*sum and 2*carry.
    assign y     = sum_q[RW-2 -: EST_W] + carry_q[RW-2 -: EST_W];
    assign d_ext = RW'(d_q);

    // Digit selection: y >= 0 -> +1, y = -1/2 -> 0, y <= -1 -> -1.
    always_comb begin
        if (!y[EST_W-1])     qd = QD_POS;
        else if (&y)         qd = QD_ZERO;
        else                 qd = QD_NEG;
    end

    // -qd*d term; the +1 of the two's complement goes in through cin.
    always_comb begin
        csa_c = '0;
        unique case (qd)
            QD_POS:  csa_c = ~d_ext;
            QD_NEG:  csa_c = d_ext;
            default: csa_c = '0;
        endcase
    end

    csa_n #(.N(RW)) u_csa (
        .a     ({sum_q[RW-2:0], 1'b0}),
        .b     ({carry_q[RW-2:0], 1'b0}),
        .c     (csa_c),
        .cin   (qd == QD_POS),
        .Sum   (csa_sum),
        .Carry (csa_carry)
    );

    // Final CPA; only its sign is needed unless the sticky bit is built.
`ifdef SRT_STICKY_EN
    logic [RW-1:0] w, rem;
    assign w     = sum_q + carry_q;
    assign w_neg = w[RW-1];
    assign rem   = w_neg ? w + d_ext : w;
`else
    assign w_neg = 1'((sum_q + carry_q) >> (RW-1));
`endif

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        d_d     = d_q;
        qa_d    = qa_q;
        qm_d    = qm_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SRT_STICKY_EN
        sticky_d = sticky_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (io.start) begin
                    d_d     = io.d;
                    sum_d   = RW'(io.x);
                    carry_d = '0;
                    qa_d    = '0;
                    qm_d    = '0;
                    cnt_d   = '0;
`ifdef SRT_STICKY_EN
                    sticky_d = 1'b0;
`endif
                    if (!io.d[WIDTH-1] || io.x >= io.d) begin
                        err_d   = 1'b1;
                        q_d     = '1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                sum_d   = csa_sum;
                carry_d = csa_carry;
                cnt_d   = cnt_q + CW'(1);
                // On-the-fly conversion keeps Q and QM = Q - 1.
                unique case (qd)
                    QD_POS: begin
                        qa_d = {qa_q[WIDTH-2:0], 1'b1};
                        qm_d = {qa_q[WIDTH-2:0], 1'b0};
                    end
                    QD_NEG: begin
                        qa_d = {qm_q[WIDTH-2:0], 1'b1};
                        qm_d = {qm_q[WIDTH-2:0], 1'b0};
                    end
                    default: begin
                        qa_d = {qa_q[WIDTH-2:0], 1'b0};
                        qm_d = {qm_q[WIDTH-2:0], 1'b1};
                    end
                endcase
                if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
            end
            FIX: begin
                q_d     = w_neg ? qm_q : qa_q;
`ifdef SRT_STICKY_EN
                sticky_d = |rem;
`endif
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sum_q   <= '0;
            carry_q <= '0;
            d_q     <= '0;
            qa_q    <= '0;
            qm_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SRT_STICKY_EN
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            d_q     <= d_d;
            qa_q    <= qa_d;
            qm_q    <= qm_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SRT_STICKY_EN
            sticky_q <= sticky_d;
`endif
        end
    end

    assign io.busy = busy_q;
    assign io.done = done_q;
    assign io.q    = q_q;
    assign io.err  = err_q;
`ifdef SRT_STICKY_EN
    assign io.sticky = sticky_q;
`endif
endmodule

// File: tb/tb_srt2_csa_div.sv
// Scoreboard bench for srt2_csa_div (WIDTH=11). Stimulus pushes expected
// results; a negedge monitor pops and compares on every done pulse.
// Sticky checks are active when SRT_STICKY_EN is defined.
module tb_srt2_csa_div;
    localparam int unsigned W = 11;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    srt2_csa_div_if #(.WIDTH(W)) bus ();
    srt2_csa_div #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .io(bus));

    typedef struct {
        logic [W-1:0] q;
        logic         err;
        logic         sticky;
        int           lat;
        int           acc;
    } exp_t;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] d;
        logic [W-1:0] q;
        logic         err;
        logic         sticky;
    } vec_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1, expected no result (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("q", 32'(bus.q), 32'(e.q));
                chk("err", 32'(bus.err), 32'(e.err));
                chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                chk("busy_at_done", 32'(bus.busy), 32'd0);
`ifdef SRT_STICKY_EN
                chk("sticky", 32'(bus.sticky), 32'(e.sticky));
`endif
            end
        end
    end

    // Present a request at the current negedge; drop start at the next one.
    task automatic issue(input logic [W-1:0] xi, input logic [W-1:0] di, input bit push,
                         input logic [W-1:0] eq, input logic ee, input logic es);
        exp_t e;
        bus.start = 1'b1;
        bus.x     = xi;
        bus.d     = di;
        if (push) begin
            e.q = eq; e.err = ee; e.sticky = es;
            e.lat = ee ? 1 : int'(W) + 2;
            e.acc = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Return at the negedge where done is seen, or report a timeout.
    task automatic wait_done();
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.done !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got no done in 40 cycles, expected done (t=%0t)", $time);
            sb.delete();
        end
    endtask

    task automatic run(input logic [W-1:0] xi, input logic [W-1:0] di,
                       input logic [W-1:0] eq, input logic ee, input logic es);
        issue(xi, di, 1'b1, eq, ee, es);
        wait_done();
        @(negedge clk);
    endtask

    vec_t vecs[10] = '{
        '{11'h400, 11'h600, 11'h555, 1'b0, 1'b1},
        '{11'h7FE, 11'h7FF, 11'h7FE, 1'b0, 1'b1},
        '{11'h000, 11'h400, 11'h000, 1'b0, 1'b0},
        '{11'h001, 11'h400, 11'h002, 1'b0, 1'b0},
        '{11'h100, 11'h3FF, 11'h7FF, 1'b1, 1'b0},
        '{11'h600, 11'h600, 11'h7FF, 1'b1, 1'b0},
        '{11'h200, 11'h400, 11'h400, 1'b0, 1'b0},
        '{11'h3FF, 11'h400, 11'h7FE, 1'b0, 1'b0},
        '{11'h100, 11'h7FF, 11'h100, 1'b0, 1'b1},
        '{11'h000, 11'h7FF, 11'h000, 1'b0, 1'b0}
    };

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected completion (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; bus.start = 1'b0; bus.x = '0; bus.d = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_q",    32'(bus.q),    32'd0);
        chk("rst_err",  32'(bus.err),  32'd0);
`ifdef SRT_STICKY_EN
        chk("rst_sticky", 32'(bus.sticky), 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors, issued back-to-back in the cycle after each done.
        foreach (vecs[i]) run(vecs[i].x, vecs[i].d, vecs[i].q, vecs[i].err, vecs[i].sticky);

        // Second start 3 cycles into a divide is ignored.
        issue(11'h400, 11'h600, 1'b1, 11'h555, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        issue(11'h7FE, 11'h7FF, 1'b0, '0, 1'b0, 1'b0);
        wait_done();

        // Start in the DONE cycle is ignored.
        bus.start = 1'b1; bus.x = 11'h100; bus.d = 11'h400;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_after_done_start", 32'(bus.busy), 32'd0);

        // Start together with reset is ignored.
        reset = 1'b1; bus.start = 1'b1; bus.x = 11'h400; bus.d = 11'h600;
        @(negedge clk);
        reset = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        chk("start_in_reset_busy", 32'(bus.busy), 32'd0);
        repeat (20) @(negedge clk);

        // Reset mid-divide aborts without done.
        issue(11'h400, 11'h600, 1'b0, '0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("mid_busy_before_reset", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        repeat (20) @(negedge clk);
        run(11'h400, 11'h600, 11'h555, 1'b0, 1'b1);

        // Sweep of normalised pairs against the floor-division model.
        for (int k = 0; k < 1000; k++) begin
            int dd, xx, num;
            dd  = int'($urandom_range(2047, 1024));
            xx  = int'($urandom_range(dd - 1, 0));
            num = xx * 2048;
            run(W'(xx), W'(dd), W'(num / dd), 1'b0, (num % dd) != 0);
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
